// File: rtl/vector_mul_vector_pipe.sv
// vector_mul_vector_pipe: two-stage valid/ready lane-wise signed multiplier with Q-format rounding and saturation
module vector_mul_vector_pipe #(
  parameter int LANES = 5,
  parameter int WIDTH = 32,
  parameter int FRAC = 31,
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic                   in_last,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [LANES-1:0]       out_sat,
  output logic [CNTW-1:0]        sat_count
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [PW-1:0] MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic s1_valid, s1_mode, s1_last, s1_adv, s2_adv;
  logic [LANES*PW-1:0] s1_prod, prod;
  logic [LANES*WIDTH-1:0] res;
  logic [LANES-1:0] sat;
  logic [CNTW:0] pc, nxt;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0] xa, xb, p, r;
    assign xa = {{WIDTH{in_a[i*WIDTH+WIDTH-1]}}, in_a[i*WIDTH +: WIDTH]};
    assign xb = {{WIDTH{in_b[i*WIDTH+WIDTH-1]}}, in_b[i*WIDTH +: WIDTH]};
    assign prod[i*PW +: PW] = xa * xb;
    assign p = s1_prod[i*PW +: PW];
    // products never reach the top bit, so adding the rounding constant cannot overflow
    assign r = s1_mode ? (p + RND) >>> FRAC : p;
    assign sat[i] = (r > MAXV) || (r < MINV);
    assign res[i*WIDTH +: WIDTH] = r > MAXV ? MAXV[WIDTH-1:0] : r < MINV ? MINV[WIDTH-1:0] : r[WIDTH-1:0];
  end
  always_comb begin
    pc = '0;
    for (int k = 0; k < LANES; k++) pc = pc + {{CNTW{1'b0}}, out_sat[k]};
    nxt = {1'b0, sat_count} + pc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode <= 1'b0;
      s1_last <= 1'b0;
      s1_prod <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_result <= '0;
      out_sat <= '0;
      sat_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= in_mode;
          s1_last <= in_last;
          s1_prod <= prod;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_last <= s1_last;
          out_result <= res;
          out_sat <= sat;
        end
      end
      if (out_valid && out_ready) sat_count <= nxt[CNTW] ? '1 : nxt[CNTW-1:0];
    end
  end
endmodule
